// File: rtl/axi_slave_pkg.sv
// Shared codes, FSM encodings and response helpers for the AXI3 SRAM slave.
// Response ranking used when folding per-beat results: DECERR > SLVERR > OKAY.
package axi_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Every beat moves one 32-bit word; arsize/awsize are not honoured.
    localparam int unsigned BEAT_BYTES = 4;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rstate_e;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_e;

    // An unsupported burst type poisons the whole burst before range is considered.
    function automatic logic [1:0] beat_resp(input logic [1:0] burst, input logic out_of_range);
        if (burst != BURST_FIXED && burst != BURST_INCR) begin
            return RESP_SLVERR;
        end
        if (out_of_range) begin
            return RESP_DECERR;
        end
        return RESP_OKAY;
    endfunction

    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        if (a == RESP_DECERR || b == RESP_DECERR) begin
            return RESP_DECERR;
        end
        if (a == RESP_SLVERR || b == RESP_SLVERR) begin
            return RESP_SLVERR;
        end
        return RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_sram_mem.sv
// Word-addressed SRAM: one combinational read port, one byte-enabled write port.
// A read and a write to the same word in one cycle returns the pre-write data.
module axi_sram_mem
    import axi_slave_pkg::*;
#(
    parameter int MEM_WORDS = 1024,
    parameter int DATA_W    = 32,
    parameter int IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic                  clk,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  we,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     wdata
);

    logic [DATA_W-1:0] mem [MEM_WORDS];

    assign rd_data = mem[rd_idx];

    // NOTE: the array has no reset on purpose; clearing it would need a
    // per-word reset path, and software never relies on power-up contents.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (wstrb[b]) begin
                    mem[wr_idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave in front of an on-chip SRAM; independent read and write FSMs,
// registered R/B outputs, one beat per cycle, no overlap of bursts per channel.
module axi_sram_slave
    import axi_slave_pkg::*;
#(
    parameter int ID_W      = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int LEN_W     = 8,
    parameter int MEM_WORDS = 1024
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic [ID_W-1:0]      arid,
    input  logic [ADDR_W-1:0]    araddr,
    input  logic [LEN_W-1:0]     arlen,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arburst,
    input  logic                 arvalid,
    output logic                 arready,

    output logic [ID_W-1:0]      rid,
    output logic [DATA_W-1:0]    rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic                 rvalid,
    input  logic                 rready,

    input  logic [ID_W-1:0]      awid,
    input  logic [ADDR_W-1:0]    awaddr,
    input  logic [LEN_W-1:0]     awlen,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awburst,
    input  logic                 awvalid,
    output logic                 awready,

    input  logic [ID_W-1:0]      wid,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [DATA_W/8-1:0]  wstrb,
    input  logic                 wlast,
    input  logic                 wvalid,
    output logic                 wready,

    output logic [ID_W-1:0]      bid,
    output logic [1:0]           bresp,
    output logic                 bvalid,
    input  logic                 bready
);

    localparam int IDX_W = $clog2(MEM_WORDS);
    localparam logic [ADDR_W-3:0] WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);
    localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(BEAT_BYTES);

    function automatic logic out_of_range(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:2] >= WORD_LIMIT;
    endfunction

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                    input logic [1:0]        burst);
        return (burst == BURST_INCR) ? addr + ADDR_STEP : addr;
    endfunction

    // Size and W-channel ID carry no information for this slave.
    logic unused_ok;
    assign unused_ok = ^{arsize, awsize, wid};

    logic              en_q;
    logic [IDX_W-1:0]  mem_rd_idx;
    logic [DATA_W-1:0] mem_rd_data;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_wr_idx;

    axi_sram_mem #(
        .MEM_WORDS (MEM_WORDS),
        .DATA_W    (DATA_W),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk     (clk),
        .rd_idx  (mem_rd_idx),
        .rd_data (mem_rd_data),
        .we      (mem_we),
        .wr_idx  (mem_wr_idx),
        .wstrb   (wstrb),
        .wdata   (wdata)
    );

    // Holds both address channels closed for one cycle after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_q <= 1'b0;
        end else begin
            en_q <= 1'b1;
        end
    end

    // ---------------- read path ----------------
    rstate_e           rstate_q, rstate_d;
    logic [ID_W-1:0]   rid_q, rid_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [LEN_W-1:0]  rlen_q, rlen_d;
    logic [1:0]        rburst_q, rburst_d;
    logic [LEN_W-1:0]  rbeat_q, rbeat_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rlast_q, rlast_d;

    logic              r_idle;
    logic              r_load;
    logic [ADDR_W-1:0] r_beat_addr;
    logic [1:0]        r_beat_burst;
    logic [LEN_W-1:0]  r_beat_idx;
    logic [LEN_W-1:0]  r_beat_len;
    logic [1:0]        r_beat_resp;

    // The beat about to be loaded: beat 0 straight from AR, else the successor.
    assign r_idle       = (rstate_q == R_IDLE);
    assign arready      = r_idle && en_q;
    assign r_beat_addr  = r_idle ? araddr  : next_addr(raddr_q, rburst_q);
    assign r_beat_burst = r_idle ? arburst : rburst_q;
    assign r_beat_idx   = r_idle ? '0      : rbeat_q + 1'b1;
    assign r_beat_len   = r_idle ? arlen   : rlen_q;
    assign r_beat_resp  = beat_resp(r_beat_burst, out_of_range(r_beat_addr));
    assign mem_rd_idx   = r_beat_addr[IDX_W+1:2];

    // NOTE: every signal gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    always_comb begin
        rstate_d = rstate_q;
        rid_d    = rid_q;
        raddr_d  = raddr_q;
        rlen_d   = rlen_q;
        rburst_d = rburst_q;
        rbeat_d  = rbeat_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;
        r_load   = 1'b0;

        unique case (rstate_q)
            R_IDLE: begin
                if (arvalid && arready) begin
                    rstate_d = R_DATA;
                    rid_d    = arid;
                    rlen_d   = arlen;
                    rburst_d = arburst;
                    r_load   = 1'b1;
                end
            end
            R_DATA: begin
                if (rready) begin
                    if (rlast_q) begin
                        rstate_d = R_IDLE;
                        rvalid_d = 1'b0;
                        rlast_d  = 1'b0;
                    end else begin
                        r_load = 1'b1;
                    end
                end
            end
            default: rstate_d = R_IDLE;
        endcase

        if (r_load) begin
            raddr_d  = r_beat_addr;
            rbeat_d  = r_beat_idx;
            rvalid_d = 1'b1;
            rresp_d  = r_beat_resp;
            rdata_d  = (r_beat_resp == RESP_OKAY) ? mem_rd_data : '0;
            rlast_d  = (r_beat_idx == r_beat_len);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rstate_q <= R_IDLE;
            rid_q    <= '0;
            raddr_q  <= '0;
            rlen_q   <= '0;
            rburst_q <= '0;
            rbeat_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            rid_q    <= rid_d;
            raddr_q  <= raddr_d;
            rlen_q   <= rlen_d;
            rburst_q <= rburst_d;
            rbeat_q  <= rbeat_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

    assign rid    = rid_q;
    assign rdata  = rdata_q;
    assign rresp  = rresp_q;
    assign rlast  = rlast_q;
    assign rvalid = rvalid_q;

    // ---------------- write path ----------------
    wstate_e           wstate_q, wstate_d;
    logic [ID_W-1:0]   bid_q, bid_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [LEN_W-1:0]  wlen_q, wlen_d;
    logic [1:0]        wburst_q, wburst_d;
    logic [LEN_W-1:0]  wbeat_q, wbeat_d;
    logic              wover_q, wover_d;
    logic              werr_q, werr_d;
    logic [1:0]        wacc_q, wacc_d;
    logic              wready_q, wready_d;
    logic              bvalid_q, bvalid_d;
    logic [1:0]        bresp_q, bresp_d;

    logic              w_hs;
    logic              w_final;
    logic [1:0]        w_beat_resp;

    // wover_q marks that beat len is done; any later beat is swallowed unwritten.
    assign awready     = (wstate_q == W_IDLE) && en_q;
    assign w_hs        = wvalid && wready_q;
    assign w_final     = !wover_q && (wbeat_q == wlen_q);
    assign w_beat_resp = beat_resp(wburst_q, out_of_range(waddr_q));
    assign mem_we      = w_hs && !wover_q && (w_beat_resp == RESP_OKAY);
    assign mem_wr_idx  = waddr_q[IDX_W+1:2];

    // NOTE: blocking assignments here let werr_d/wacc_d be updated and then
    // read again for bresp_d within the same evaluation; flops use <= only.
    always_comb begin
        wstate_d = wstate_q;
        bid_d    = bid_q;
        waddr_d  = waddr_q;
        wlen_d   = wlen_q;
        wburst_d = wburst_q;
        wbeat_d  = wbeat_q;
        wover_d  = wover_q;
        werr_d   = werr_q;
        wacc_d   = wacc_q;
        wready_d = wready_q;
        bvalid_d = bvalid_q;
        bresp_d  = bresp_q;

        unique case (wstate_q)
            W_IDLE: begin
                if (awvalid && awready) begin
                    wstate_d = W_DATA;
                    bid_d    = awid;
                    waddr_d  = awaddr;
                    wlen_d   = awlen;
                    wburst_d = awburst;
                    wbeat_d  = '0;
                    wover_d  = 1'b0;
                    werr_d   = 1'b0;
                    wacc_d   = RESP_OKAY;
                    wready_d = 1'b1;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (!wover_q) begin
                        wacc_d  = resp_worst(wacc_q, w_beat_resp);
                        waddr_d = next_addr(waddr_q, wburst_q);
                        if (w_final) begin
                            wover_d = 1'b1;
                        end else begin
                            wbeat_d = wbeat_q + 1'b1;
                        end
                    end
                    if (wlast != w_final) begin
                        werr_d = 1'b1;
                    end
                    if (wlast) begin
                        wstate_d = W_RESP;
                        wready_d = 1'b0;
                        bvalid_d = 1'b1;
                        bresp_d  = werr_d ? RESP_SLVERR : wacc_d;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    wstate_d = W_IDLE;
                    bvalid_d = 1'b0;
                end
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wstate_q <= W_IDLE;
            bid_q    <= '0;
            waddr_q  <= '0;
            wlen_q   <= '0;
            wburst_q <= '0;
            wbeat_q  <= '0;
            wover_q  <= 1'b0;
            werr_q   <= 1'b0;
            wacc_q   <= RESP_OKAY;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else begin
            wstate_q <= wstate_d;
            bid_q    <= bid_d;
            waddr_q  <= waddr_d;
            wlen_q   <= wlen_d;
            wburst_q <= wburst_d;
            wbeat_q  <= wbeat_d;
            wover_q  <= wover_d;
            werr_q   <= werr_d;
            wacc_q   <= wacc_d;
            wready_q <= wready_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
        end
    end

    assign wready = wready_q;
    assign bid    = bid_q;
    assign bresp  = bresp_q;
    assign bvalid = bvalid_q;

endmodule
